// File: rtl/usb2_ep_pingpong_buf_pkg.sv
// Shared definitions for the multi-endpoint ping/pong IN packet buffer.
// Slot-count encodings and width helpers.
package usb2_ep_pingpong_buf_pkg;

    typedef logic [1:0] slot_cnt_t;

    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_FULL  = 2'd2;

    function automatic int ep_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/usb2_ep_pingpong_buf_slot_ctl.sv
// Per-endpoint slot controller: fill/drain pointers, packet count,
// stored lengths and commit/done/flush arbitration.
module usb2_ep_pingpong_buf_slot_ctl
    import usb2_ep_pingpong_buf_pkg::*;
#(
    parameter int LEN_W   = 10,
    parameter int MAX_PKT = 512
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             commit_i,
    input  logic [LEN_W-1:0] commit_len_i,
    input  logic             done_i,
    input  logic             flush_i,
    output logic             wp_o,
    output logic             rp_o,
    output slot_cnt_t        cnt_o,
    output logic [LEN_W-1:0] len_o,
    output logic             commit_acc_o,
    output logic             commit_rej_o,
    output logic             done_acc_o
);

    logic             wp_q, wp_d;
    logic             rp_q, rp_d;
    slot_cnt_t        cnt_q, cnt_d;
    logic [LEN_W-1:0] len0_q, len0_d;
    logic [LEN_W-1:0] len1_q, len1_d;
    logic             len_ok;
    logic             has_room;

    always_comb begin
        len_ok   = (commit_len_i <= LEN_W'(MAX_PKT));
        has_room = (cnt_q != CNT_FULL);
        // Commit is judged on the pre-done count, so FULL+done still rejects.
        commit_acc_o = commit_i && !flush_i && has_room && len_ok;
        commit_rej_o = commit_i && !flush_i && !(has_room && len_ok);
        done_acc_o   = done_i && !flush_i && (cnt_q != CNT_EMPTY);

        wp_d   = wp_q;
        rp_d   = rp_q;
        cnt_d  = cnt_q;
        len0_d = len0_q;
        len1_d = len1_q;

        if (flush_i) begin
            cnt_d = CNT_EMPTY;
            rp_d  = wp_q;
        end else begin
            if (commit_acc_o) begin
                wp_d = ~wp_q;
                if (wp_q) len1_d = commit_len_i;
                else      len0_d = commit_len_i;
            end
            if (done_acc_o) rp_d = ~rp_q;
            unique case ({commit_acc_o, done_acc_o})
                2'b10:   cnt_d = cnt_q + 2'd1;
                2'b01:   cnt_d = cnt_q - 2'd1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wp_q   <= 1'b0;
            rp_q   <= 1'b0;
            cnt_q  <= CNT_EMPTY;
            len0_q <= '0;
            len1_q <= '0;
        end else begin
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            cnt_q  <= cnt_d;
            len0_q <= len0_d;
            len1_q <= len1_d;
        end
    end

    assign wp_o  = wp_q;
    assign rp_o  = rp_q;
    assign cnt_o = cnt_q;
    assign len_o = rp_q ? len1_q : len0_q;

endmodule

// File: rtl/usb2_ep_pingpong_buf.sv
// Multi-endpoint ping/pong IN packet buffer with replay-until-ACK
// and per-endpoint flush, single phy_clk domain.
module usb2_ep_pingpong_buf
    import usb2_ep_pingpong_buf_pkg::*;
#(
    parameter int NUM_EP  = 4,
    parameter int DATA_W  = 8,
    parameter int MAX_PKT = 512,
    parameter int LEN_W   = 10,
    parameter int EP_W    = ep_width(NUM_EP),
    parameter int ADDR_W  = $clog2(MAX_PKT)
) (
    input  logic              phy_clk,
    input  logic              reset,
    input  logic [EP_W-1:0]   wr_endp,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_wren,
    output logic [NUM_EP-1:0] wr_ready,
    input  logic              wr_commit,
    input  logic [LEN_W-1:0]  wr_commit_len,
    output logic              wr_commit_ack,
    input  logic [EP_W-1:0]   rd_endp,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_q,
    output logic [LEN_W-1:0]  rd_len,
    output logic              rd_hasdata,
    input  logic              rd_done,
    output logic              rd_done_ack,
    input  logic [NUM_EP-1:0] ep_flush,
    output logic              err_commit
);

    localparam int AW    = EP_W + 1 + ADDR_W;
    localparam int DEPTH = 1 << AW;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [NUM_EP-1:0] wp;
    logic [NUM_EP-1:0] rp;
    logic [NUM_EP-1:0] c_acc;
    logic [NUM_EP-1:0] c_rej;
    logic [NUM_EP-1:0] d_acc;
    slot_cnt_t         cnt  [NUM_EP];
    logic [LEN_W-1:0]  dlen [NUM_EP];

    logic              wr_full;
    logic              wr_slot;
    logic              rd_slot;
    logic [DATA_W-1:0] rdata_q;
    logic              commit_ack_q;
    logic              commit_err_q;
    logic              done_ack_q;

    for (genvar i = 0; i < NUM_EP; i++) begin : g_ep
        usb2_ep_pingpong_buf_slot_ctl #(
            .LEN_W   (LEN_W),
            .MAX_PKT (MAX_PKT)
        ) u_slot (
            .clk_i        (phy_clk),
            .rst_i        (reset),
            .commit_i     (wr_commit && (wr_endp == EP_W'(i))),
            .commit_len_i (wr_commit_len),
            .done_i       (rd_done && (rd_endp == EP_W'(i))),
            .flush_i      (ep_flush[i]),
            .wp_o         (wp[i]),
            .rp_o         (rp[i]),
            .cnt_o        (cnt[i]),
            .len_o        (dlen[i]),
            .commit_acc_o (c_acc[i]),
            .commit_rej_o (c_rej[i]),
            .done_acc_o   (d_acc[i])
        );
        assign wr_ready[i] = (cnt[i] != CNT_FULL);
    end

    always_comb begin
        wr_full    = (cnt[wr_endp] == CNT_FULL);
        wr_slot    = wp[wr_endp];
        rd_slot    = rp[rd_endp];
        rd_hasdata = (cnt[rd_endp] != CNT_EMPTY);
        rd_len     = dlen[rd_endp];
    end

    // When FULL the fill pointer aliases the drain slot, so drop writes.
    always_ff @(posedge phy_clk) begin
        if (wr_wren && !wr_full)
            mem[{wr_endp, wr_slot, wr_addr}] <= wr_data;
    end

    always_ff @(posedge phy_clk or posedge reset) begin
        if (reset) begin
            rdata_q      <= '0;
            commit_ack_q <= 1'b0;
            commit_err_q <= 1'b0;
            done_ack_q   <= 1'b0;
        end else begin
            rdata_q      <= mem[{rd_endp, rd_slot, rd_addr}];
            commit_ack_q <= |c_acc;
            commit_err_q <= |c_rej;
            done_ack_q   <= |d_acc;
        end
    end

    assign rd_q          = rdata_q;
    assign wr_commit_ack = commit_ack_q;
    assign err_commit    = commit_err_q;
    assign rd_done_ack   = done_ack_q;

endmodule
